// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one stb/ack single-precision FP adder between four requesters.
// Round-robin grants by default; define ADDER_ARB_PRIORITY_EN for fixed lowest-index-wins.
module adder_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_stb,
  output logic [NREQ-1:0]       req_ack,
  output logic [WIDTH-1:0]      resp_z,
  output logic [NREQ-1:0]       resp_stb,
  input  logic [NREQ-1:0]       resp_ack,
  output logic [WIDTH-1:0]      adder_a,
  output logic                  adder_a_stb,
  input  logic                  adder_a_ack,
  output logic [WIDTH-1:0]      adder_b,
  output logic                  adder_b_stb,
  input  logic                  adder_b_ack,
  input  logic [WIDTH-1:0]      adder_z,
  input  logic                  adder_z_stb,
  output logic                  adder_z_ack
);
  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [2:0] {ARB, TAKE, SEND_A, SEND_B, WAIT_Z, PUT_Z} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    winner;
`ifndef ADDER_ARB_PRIORITY_EN
  logic [GW-1:0]    ptr_q, ptr_d;
`endif
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] adder_a_q, adder_a_d;
  logic [WIDTH-1:0] adder_b_q, adder_b_d;
  logic [WIDTH-1:0] resp_z_q, resp_z_d;
  logic [NREQ-1:0]  req_ack_q, req_ack_d;
  logic [NREQ-1:0]  resp_stb_q, resp_stb_d;
  logic             a_stb_q, a_stb_d;
  logic             b_stb_q, b_stb_d;
  logic             z_ack_q, z_ack_d;

  // Winner search; the last assignment in the loop has the highest priority.
  always_comb begin
    winner = '0;
`ifdef ADDER_ARB_PRIORITY_EN
    for (int i = int'(NREQ) - 1; i >= 0; i--)
      if (req_stb[i]) winner = GW'(i);
`else
    for (int k = int'(NREQ); k >= 1; k--)
      if (req_stb[ptr_q + GW'(k)]) winner = ptr_q + GW'(k);
`endif
  end

  // Operand a is captured straight into the adder_a register, so it doubles as op_a.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
`ifndef ADDER_ARB_PRIORITY_EN
    ptr_d      = ptr_q;
`endif
    op_b_d     = op_b_q;
    adder_a_d  = adder_a_q;
    adder_b_d  = adder_b_q;
    resp_z_d   = resp_z_q;
    req_ack_d  = req_ack_q;
    resp_stb_d = resp_stb_q;
    a_stb_d    = a_stb_q;
    b_stb_d    = b_stb_q;
    z_ack_d    = z_ack_q;
    case (state_q)
      ARB: begin
        if (|req_stb) begin
          grant_d   = winner;
`ifndef ADDER_ARB_PRIORITY_EN
          ptr_d     = winner;
`endif
          req_ack_d = NREQ'(1) << winner;
          state_d   = TAKE;
        end
      end
      TAKE: begin
        if (req_stb[grant_q] && req_ack_q[grant_q]) begin
          adder_a_d = req_a[32'(grant_q) * WIDTH +: WIDTH];
          op_b_d    = req_b[32'(grant_q) * WIDTH +: WIDTH];
          req_ack_d = '0;
          a_stb_d   = 1'b1;
          state_d   = SEND_A;
        end
      end
      SEND_A: begin
        if (a_stb_q && adder_a_ack) begin
          a_stb_d   = 1'b0;
          adder_b_d = op_b_q;
          b_stb_d   = 1'b1;
          state_d   = SEND_B;
        end
      end
      SEND_B: begin
        if (b_stb_q && adder_b_ack) begin
          b_stb_d = 1'b0;
          z_ack_d = 1'b1;
          state_d = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (adder_z_stb && z_ack_q) begin
          resp_z_d   = adder_z;
          z_ack_d    = 1'b0;
          resp_stb_d = NREQ'(1) << grant_q;
          state_d    = PUT_Z;
        end
      end
      PUT_Z: begin
        if (resp_stb_q[grant_q] && resp_ack[grant_q]) begin
          resp_stb_d = '0;
          state_d    = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      grant_q    <= '0;
`ifndef ADDER_ARB_PRIORITY_EN
      ptr_q      <= GW'(NREQ - 1);
`endif
      op_b_q     <= '0;
      adder_a_q  <= '0;
      adder_b_q  <= '0;
      resp_z_q   <= '0;
      req_ack_q  <= '0;
      resp_stb_q <= '0;
      a_stb_q    <= 1'b0;
      b_stb_q    <= 1'b0;
      z_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
`ifndef ADDER_ARB_PRIORITY_EN
      ptr_q      <= ptr_d;
`endif
      op_b_q     <= op_b_d;
      adder_a_q  <= adder_a_d;
      adder_b_q  <= adder_b_d;
      resp_z_q   <= resp_z_d;
      req_ack_q  <= req_ack_d;
      resp_stb_q <= resp_stb_d;
      a_stb_q    <= a_stb_d;
      b_stb_q    <= b_stb_d;
      z_ack_q    <= z_ack_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign resp_stb    = resp_stb_q;
  assign resp_z      = resp_z_q;
  assign adder_a     = adder_a_q;
  assign adder_a_stb = a_stb_q;
  assign adder_b     = adder_b_q;
  assign adder_b_stb = b_stb_q;
  assign adder_z_ack = z_ack_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter with a behavioural stb/ack FP adder
// (operands restricted to exact half-integers) and a grant-order reference model.
module tb_adder_arbiter;
  logic         clk, rst;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_stb, req_ack, resp_stb, resp_ack;
  logic [31:0]  resp_z, adder_a, adder_b, adder_z;
  logic         adder_a_stb, adder_a_ack, adder_b_stb, adder_b_ack;
  logic         adder_z_stb, adder_z_ack;

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic [31:0] z; } item_t;
  typedef struct packed { logic [1:0] idx; logic [31:0] z; } exp_t;

  item_t rq [4][$];
  exp_t  sb [$];
  item_t cur [4];
  int    n_vec, n_err;
  int    a_stall, b_stall, hold1, last_grant;
  bit    z_hold;
  logic [3:0] acc, stb_arb;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
    .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
    .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
    .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
    end
  endtask

  // Value n/2 encoded as an IEEE single.
  function automatic logic [31:0] fp_of_half(input int unsigned n);
    int p;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (n[i]) p = i;
    m = n << (23 - p);
    return {1'b0, 8'(126 + p), m[22:0]};
  endfunction

  function automatic int unsigned half_of_fp(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f == 32'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {9'h001, f[22:0]};
    return m >> (22 - e);
  endfunction

  function automatic int predict(input logic [3:0] s, input int last);
`ifdef ADDER_ARB_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (s[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (s[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
    item_t it;
    it.a = a; it.b = b; it.z = z;
    rq[i].push_back(it);
  endtask

  task automatic push_rand(input int i);
    int unsigned na = $urandom_range(0, 2047);
    int unsigned nb = $urandom_range(0, 2047);
    push(i, fp_of_half(na), fp_of_half(nb), fp_of_half(na + nb));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_resp_stb"}, 32'(resp_stb), 32'h0);
    chk({tag, "_adder_stbs"}, 32'({adder_a_stb, adder_b_stb, adder_z_ack}), 32'h0);
    chk({tag, "_resp_z"}, resp_z, 32'h0);
    chk({tag, "_adder_a"}, adder_a, 32'h0);
    chk({tag, "_adder_b"}, adder_b, 32'h0);
  endtask

  function automatic bit busy();
    for (int i = 0; i < 4; i++) if (rq[i].size() != 0) return 1'b1;
    return (req_stb != 0) || (acc != 0) || (sb.size() != 0) || (resp_stb != 0);
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy() && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout waiting for idle, %0d queued responses", name, sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Requesters: present queued operand pairs, check grant order, push expected result.
  initial begin : requesters
    req_stb = '0; req_a = '0; req_b = '0; acc = '0; stb_arb = '0; last_grant = 3;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_stb = '0; acc = '0; stb_arb = '0; last_grant = 3;
        continue;
      end
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin req_stb[i] = 1'b0; acc[i] = 1'b0; end
        if (!req_stb[i] && rq[i].size() > 0) begin
          cur[i] = rq[i].pop_front();
          req_a[32*i +: 32] = cur[i].a;
          req_b[32*i +: 32] = cur[i].b;
          req_stb[i] = 1'b1;
        end
      end
      if ((req_stb & req_ack) != 0) begin
        int obs, want;
        obs = 0;
        for (int i = 3; i >= 0; i--) if (req_stb[i] && req_ack[i]) obs = i;
        want = predict(stb_arb, last_grant);
        chk("grant", 32'(obs), 32'(want));
        if (want >= 0) begin
          sb.push_back({2'(want), cur[want].z});
          last_grant = want;
        end
        acc[obs] = 1'b1;
      end
      stb_arb = req_stb;
    end
  end

  // Behavioural adder on the adder side of the arbiter.
  initial begin : adder_model
    int ph;
    logic [31:0] got_a, prev_a, prev_b;
    logic prev_a_stb, prev_b_stb;
    adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0; adder_z = '0;
    ph = 0; got_a = '0; prev_a = '0; prev_b = '0; prev_a_stb = 1'b0; prev_b_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0; adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0;
        prev_a_stb = 1'b0; prev_b_stb = 1'b0;
        continue;
      end
      if (prev_a_stb && adder_a_stb) chk("adder_a_stable", adder_a, prev_a);
      if (prev_b_stb && adder_b_stb) chk("adder_b_stable", adder_b, prev_b);
      chk("adder_stb_excl", 32'($countones({adder_a_stb, adder_b_stb, adder_z_ack}) <= 1), 32'h1);
      prev_a_stb = adder_a_stb; prev_a = adder_a;
      prev_b_stb = adder_b_stb; prev_b = adder_b;
      adder_a_ack = (ph == 0) && (a_stall == 0);
      adder_b_ack = (ph == 1) && (b_stall == 0);
      adder_z_stb = (ph == 2) && !z_hold;
      if (ph == 0 && adder_a_stb && a_stall > 0) a_stall--;
      if (ph == 1 && adder_b_stb && b_stall > 0) b_stall--;
      if (adder_a_stb && adder_a_ack) begin
        got_a = adder_a; ph = 1;
      end else if (adder_b_stb && adder_b_ack) begin
        adder_z = fp_of_half(half_of_fp(got_a) + half_of_fp(adder_b)); ph = 2;
      end else if (adder_z_stb && adder_z_ack) begin
        ph = 0;
      end
    end
  end

  // Response monitor: random consumers, pops the scoreboard on each result transfer.
  initial begin : monitor
    logic [3:0] prev_stb;
    logic [31:0] prev_z;
    bit pend;
    exp_t e;
    resp_ack = '0; pend = 1'b0; prev_stb = '0; prev_z = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_ack = '0; pend = 1'b0; sb.delete();
        continue;
      end
      chk("req_ack_onehot", 32'($onehot0(req_ack)), 32'h1);
      chk("resp_stb_onehot", 32'($onehot0(resp_stb)), 32'h1);
      if (pend) begin
        chk("resp_stb_held", 32'(resp_stb), 32'(prev_stb));
        chk("resp_z_held", resp_z, prev_z);
        chk("no_grant_while_resp", 32'({req_ack, adder_a_stb}), 32'h0);
      end
      resp_ack = 4'($urandom());
      if (resp_stb[1] && hold1 > 0) begin
        resp_ack[1] = 1'b0;
        hold1--;
      end
      if ((resp_stb & resp_ack) != 0) begin
        pend = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(resp_stb), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("resp_idx", 32'(resp_stb), 32'(4'(1) << e.idx));
          chk("resp_z", resp_z, e.z);
        end
      end else begin
        pend = (resp_stb != 0);
      end
      prev_stb = resp_stb; prev_z = resp_z;
    end
  end

  initial begin : main
    logic [31:0] z4 [4];
    int n;
    rst = 1'b1; a_stall = 0; b_stall = 0; hold1 = 0; z_hold = 1'b0; n_vec = 0; n_err = 0;
    z4[0] = 32'h3FC00000; z4[1] = 32'h40200000; z4[2] = 32'h40600000; z4[3] = 32'h40900000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1 rst = 1'b0;

    push(2, 32'h3F800000, 32'h40000000, 32'h40400000);
    wait_idle("single");

    for (int i = 0; i < 4; i++) push(i, 32'h3FC00000, fp_of_half(2 * i), z4[i]);
    wait_idle("all_four");

    hold1 = 20;
    push(1, 32'h40800000, 32'h3FC00000, 32'h40B00000);
    push(2, 32'h3F800000, 32'h3F800000, 32'h40000000);
    wait_idle("slow_consumer");

    a_stall = 10; b_stall = 5;
    push(0, 32'h40C00000, 32'h3F800000, 32'h40E00000);
    wait_idle("backpressure");

    z_hold = 1'b1;
    push(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    n = 0;
    while (!adder_z_ack && n < 200) begin @(posedge clk); #1; n++; end
    chk("reach_wait_z", 32'(adder_z_ack), 32'h1);
    rst = 1'b1; z_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("mid");
    @(posedge clk); #1 rst = 1'b0;
    push(1, 32'h40000000, 32'h3FC00000, 32'h40600000);
    push(0, 32'h3F800000, 32'h40400000, 32'h40800000);
    wait_idle("after_reset");

    for (int k = 0; k < 3; k++) push_rand(3);
    n = 0;
    while (!adder_a_stb && n < 200) begin @(posedge clk); #1; n++; end
    push(0, 32'h40A00000, 32'h40A00000, 32'h41200000);
    wait_idle("repeat_req3");

    for (int t = 0; t < 250; t++) begin
      int r = int'($urandom_range(0, 3));
      if (rq[r].size() < 2) push_rand(r);
      if ($urandom_range(0, 9) == 0 && a_stall == 0) a_stall = int'($urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0 && b_stall == 0) b_stall = int'($urandom_range(1, 4));
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1;
    end
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
